// File: rtl/hog_cell_hist.sv
// 9-bin HOG cell histogram: accumulates CELL_PIX (code, magnitude) pairs, then drains from a shadow.
// Optional `HOG_CELL_HIST_SUM_EN appends a tenth beat carrying the saturated sum of all bins.
module hog_cell_hist #(
    parameter int unsigned MAG_W    = 8,
    parameter int unsigned CELL_PIX = 64,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned N_BINS   = 9,
    parameter int unsigned BIN_W    = MAG_W + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [3:0]       i_code,
    input  logic [MAG_W-1:0] i_mag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [BIN_W-1:0] o_bin,
    output logic [3:0]       o_idx,
    output logic             o_last,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CELL_PIX - 1);
`ifdef HOG_CELL_HIST_SUM_EN
    localparam logic [3:0] IdxLast = 4'(N_BINS);
`else
    localparam logic [3:0] IdxLast = 4'(N_BINS - 1);
`endif

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] acc_q    [N_BINS];
    logic [BIN_W-1:0] acc_d    [N_BINS];
    logic [BIN_W-1:0] shadow_q [N_BINS];
    logic [BIN_W-1:0] shadow_d [N_BINS];
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             err_q, err_d;

    logic             shadow_busy;
    logic             accept;
    logic             code_ok;
    logic             cell_done;
    logic             beat_fire;
    logic [BIN_W-1:0] mag_ext;

    assign shadow_busy = (state_q == StSend);
    // Stall only the completing pixel, and only while the previous cell still owns the shadow.
    assign i_ready     = !rst && !(pix_cnt_q == CntLast && shadow_busy);
    assign accept      = i_valid && i_ready;
    assign code_ok     = (i_code < 4'(N_BINS));
    assign cell_done   = accept && (pix_cnt_q == CntLast);
    assign beat_fire   = o_valid && o_ready;
    assign mag_ext     = BIN_W'(i_mag);
    assign o_err       = err_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        shadow_d  = shadow_q;
        pix_cnt_d = pix_cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;

        if (accept) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (!code_ok) begin
                err_d = 1'b1;
            end
            for (int k = 0; k < int'(N_BINS); k++) begin
                if (code_ok && i_code == 4'(k)) begin
                    acc_d[k] = acc_q[k] + mag_ext;
                end
            end
        end

        if (beat_fire) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == IdxLast) begin
                state_d = StIdle;
            end
        end

        // Completion is blocked while draining, so this never overlaps a beat handshake.
        if (cell_done) begin
            shadow_d  = acc_d;
            pix_cnt_d = '0;
            idx_d     = '0;
            state_d   = StSend;
            for (int k = 0; k < int'(N_BINS); k++) begin
                acc_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pix_cnt_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            for (int k = 0; k < int'(N_BINS); k++) begin
                acc_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            for (int k = 0; k < int'(N_BINS); k++) begin
                acc_q[k]    <= acc_d[k];
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

`ifdef HOG_CELL_HIST_SUM_EN
    logic [BIN_W+3:0] sum_all;
    logic [BIN_W-1:0] sum_sat;

    always_comb begin
        sum_all = '0;
        for (int k = 0; k < int'(N_BINS); k++) begin
            sum_all = sum_all + (BIN_W+4)'(shadow_q[k]);
        end
        sum_sat = (|sum_all[BIN_W+3:BIN_W]) ? {BIN_W{1'b1}} : sum_all[BIN_W-1:0];
    end
`endif

    always_comb begin
        o_valid = !rst && shadow_busy;
        o_idx   = '0;
        o_last  = 1'b0;
        o_bin   = '0;
        if (o_valid) begin
            o_idx  = idx_q;
            o_last = (idx_q == IdxLast);
            for (int k = 0; k < int'(N_BINS); k++) begin
                if (idx_q == 4'(k)) begin
                    o_bin = shadow_q[k];
                end
            end
`ifdef HOG_CELL_HIST_SUM_EN
            if (idx_q == 4'(N_BINS)) begin
                o_bin = sum_sat;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hog_cell_hist.sv
// Self-checking bench for hog_cell_hist: directed cells plus a randomised run against a histogram model.
`timescale 1ns/1ps
module tb_hog_cell_hist;

    localparam int MAG_W    = 8;
    localparam int CELL_PIX = 64;
    localparam int CNT_W    = 6;
    localparam int BIN_W    = MAG_W + CNT_W;
    localparam int TMO      = 2000;
`ifdef HOG_CELL_HIST_SUM_EN
    localparam int N_BEATS = 10;
`else
    localparam int N_BEATS = 9;
`endif

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [3:0]       i_code  = '0;
    logic [MAG_W-1:0] i_mag   = '0;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic [BIN_W-1:0] o_bin;
    logic [3:0]       o_idx;
    logic             o_last;
    logic             o_err;

    hog_cell_hist #(
        .MAG_W    (MAG_W),
        .CELL_PIX (CELL_PIX),
        .CNT_W    (CNT_W),
        .N_BINS   (9),
        .BIN_W    (BIN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_code  (i_code),
        .i_mag   (i_mag),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_bin   (o_bin),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    m_hist[9];
    int    m_cnt;
    bit    m_err;
    int    n_acc       = 0;
    int    n_beats     = 0;
    int    n_cells_out = 0;
    int    cap_bin[10];
    int    n_checks    = 0;
    int    n_fail      = 0;
    int    rdy_mode    = 1;  // 0 hold low, 1 hold high, 2 random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        foreach (m_hist[k]) m_hist[k] = 0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Spec-level model: accumulate per bin, emit a whole cell's beats when the cell fills.
    task automatic model_accept(input int c, input int m);
        int sum;
        beat_t b;
        n_acc++;
        if (c < 9) m_hist[c] += m;
        else m_err = 1'b1;
        if (m_cnt == CELL_PIX - 1) begin
            sum = 0;
            for (int k = 0; k < 9; k++) begin
                b.bin  = m_hist[k];
                b.idx  = k;
                b.last = (k == N_BEATS - 1);
                exp_q.push_back(b);
                sum += m_hist[k];
            end
`ifdef HOG_CELL_HIST_SUM_EN
            b.bin  = (sum > (1 << BIN_W) - 1) ? (1 << BIN_W) - 1 : sum;
            b.idx  = 9;
            b.last = 1'b1;
            exp_q.push_back(b);
`endif
            foreach (m_hist[k]) m_hist[k] = 0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Compare first (state after last edge), then advance the model with this cycle's handshakes.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_i_ready", i_ready, 0);
            check("rst_o_valid", o_valid, 0);
            check("rst_o_last", o_last, 0);
            check("rst_o_bin", o_bin, 0);
            check("rst_o_idx", o_idx, 0);
            model_reset();
        end else begin
            check("i_ready", i_ready, !(m_cnt == CELL_PIX - 1 && exp_q.size() != 0));
            check("o_valid", o_valid, exp_q.size() != 0);
            check("o_err", o_err, m_err);
            if (o_valid && exp_q.size() != 0) begin
                check("o_bin", o_bin, exp_q[0].bin);
                check("o_idx", o_idx, exp_q[0].idx);
                check("o_last", o_last, exp_q[0].last);
                if (o_ready) begin
                    if (o_idx < 10) cap_bin[o_idx] = int'(o_bin);
                    n_beats++;
                    if (o_last) n_cells_out++;
                    void'(exp_q.pop_front());
                end
            end
            if (i_valid && i_ready) model_accept(int'(i_code), int'(i_mag));
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       o_ready = 1'b0;
            1:       o_ready = 1'b1;
            default: o_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input int c, input int m);
        int t = 0;
        i_valid = 1'b1;
        i_code  = 4'(c);
        i_mag   = MAG_W'(m);
        do begin
            @(negedge clk);
            t++;
        end while (!i_ready && t < TMO);
        check("send_ready", i_ready, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", exp_q.size(), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        foreach (cap_bin[k]) cap_bin[k] = -1;
        n_beats = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cells0;
        idle(1);
        do_reset();

        // 1: code=i%9, mag=1
        rdy_mode = 1;
        for (int i = 0; i < 64; i++) send(i % 9, 1);
        check("t1_first_valid", o_valid, 1);
        check("t1_first_idx", o_idx, 0);
        wait_drain();
        check("t1_bin0", cap_bin[0], 8);
        for (int k = 1; k < 9; k++) check("t1_bink", cap_bin[k], 7);
`ifdef HOG_CELL_HIST_SUM_EN
        check("t1_sum", cap_bin[9], 64);
`endif
        check("t1_beats", n_beats, N_BEATS);
        check("t1_err", o_err, 0);

        // 2: max magnitude on one bin
        do_reset();
        for (int i = 0; i < 64; i++) send(4, 255);
        wait_drain();
        check("t2_bin4", cap_bin[4], 16320);
        check("t2_bin0", cap_bin[0], 0);
        check("t2_bin8", cap_bin[8], 0);
`ifdef HOG_CELL_HIST_SUM_EN
        check("t2_sum", cap_bin[9], 16320);
`endif

        // 3: backpressure across two cells
        rdy_mode = 0;
        base     = n_acc;
        cells0   = n_cells_out;
        fork
            for (int i = 0; i < 128; i++) send(i % 9, (i % 7) + 1);
            begin
                repeat (300) @(posedge clk);
                @(negedge clk);
                check("t3_stall_ready", i_ready, 0);
                check("t3_accepted", n_acc - base, 127);
                check("t3_hold_valid", o_valid, 1);
                check("t3_hold_idx", o_idx, 0);
                rdy_mode = 1;
            end
        join
        wait_drain();
        check("t3_cells", n_cells_out - cells0, 2);
        check("t3_accepted_all", n_acc - base, 128);

        // 4: invalid code inside a cell
        do_reset();
        for (int i = 0; i < 64; i++) begin
            if (i == 20) send(12, 50);
            else send(i % 9, 3);
        end
        wait_drain();
        check("t4_bin0", cap_bin[0], 24);
        check("t4_bin2", cap_bin[2], 18);
        check("t4_bin5", cap_bin[5], 21);
        check("t4_beats", n_beats, N_BEATS);
        idle(5);
        check("t4_err_sticky", o_err, 1);

        // 5: reset mid-drain and mid-cell
        rdy_mode = 0;
        for (int i = 0; i < 64; i++) send(1, 9);
        for (int i = 0; i < 30; i++) send(3, 7);
        check("t5_pre_valid", o_valid, 1);
        do_reset();
        rdy_mode = 1;
        idle(3);
        check("t5_no_stale", n_beats, 0);
        for (int i = 0; i < 64; i++) send(0, 2);
        wait_drain();
        check("t5_bin0", cap_bin[0], 128);
        check("t5_bin1", cap_bin[1], 0);
        check("t5_bin3", cap_bin[3], 0);
        check("t5_beats", n_beats, N_BEATS);
        check("t5_err", o_err, 0);

        // 6: random traffic, 20 cells
        rdy_mode = 2;
        cells0   = n_cells_out;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send($urandom_range(0, 8), $urandom_range(0, 255));
            end
        end
        rdy_mode = 1;
        wait_drain();
        check("t6_cells", n_cells_out - cells0, 20);
        check("t6_err", o_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hog_cell_hist.md
Name: hog_cell_hist

Overview:
- Consumer end of the per-pixel orientation-bin stream.
- Accepts one (bin code, gradient magnitude) pair per pixel and accumulates a 9-bin histogram over one cell of CELL_PIX pixels.
- Once the cell is complete, streams the 9 bin sums to the block-normalisation stage over a valid/ready handshake.
- Ping-pong (accumulator + shadow) so pixel intake continues while the previous cell drains.

Parameters:
- MAG_W, 8: gradient magnitude width (unsigned).
- CELL_PIX, 64: pixels per cell; power of two, at least 2.
- CNT_W, 6: log2(CELL_PIX), pixel counter width.
- N_BINS, 9: number of orientation bins; fixed at 9, codes 0..8.
- BIN_W, MAG_W+CNT_W: bin sum width; guarantees no overflow.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_valid  in  1  pixel pair valid
- i_ready  out  1  pixel pair accepted when i_valid && i_ready
- i_code  in  4  orientation bin code, 0..8
- i_mag  in  MAG_W  gradient magnitude
- o_valid  out  1  histogram beat valid
- o_ready  in  1  downstream accepts beat
- o_bin  out  BIN_W  bin sum for beat
- o_idx  out  4  bin index of beat, 0..8
- o_last  out  1  final beat of cell
- o_err  out  1  sticky: invalid code seen

Behaviour:
- Reset (rst=1 at posedge): clears all accumulators, shadow, pix_cnt, idx and o_err, and sets state=IDLE. While rst is high: i_ready=0, o_valid=0, o_last=0, o_bin=0, o_idx=0.
- Accept: on i_valid && i_ready:
  - acc[i_code] += i_mag (zero-extended to BIN_W);
  - pix_cnt += 1, wrapping at CELL_PIX.
- Invalid code (9..15): the pixel still counts toward pix_cnt, the magnitude is discarded, and o_err is set. o_err clears only on reset.
- Cell completion: an accept with pix_cnt==CELL_PIX-1.
  - Next cycle: shadow[k] = acc[k] including the final pixel's add, acc cleared to 0, pix_cnt=0, shadow_busy=1, state=SEND, idx=0.
- i_ready = !rst && !(pix_cnt==CELL_PIX-1 && shadow_busy).
  - Purely state-based; no combinational path from o_ready.
  - A stall costs one extra cycle after shadow frees; this is accepted.
- Output FSM:
  - IDLE: o_valid=0.
  - SEND: o_valid=1, o_bin=shadow[idx], o_idx=idx, o_last=(idx==8).
  - On o_valid && o_ready: idx += 1. On the o_last handshake: state=IDLE, shadow_busy=0.
- o_bin, o_idx and o_last hold stable while o_valid && !o_ready.
- Latency: first beat is valid 1 cycle after the completing accept. The minimum drain is 9 cycles with o_ready held high.
- Back-to-back cells: intake is never stalled if the drain finishes before the next cell's last pixel arrives. CELL_PIX >= 10 guarantees this when o_ready is held high.
- Reset mid-cell or mid-drain: the partial cell is discarded and no beats are emitted.

Optional Feature:
- Macro HOG_CELL_HIST_SUM_EN.
- Defined: a tenth beat follows bin 8, with o_idx=9 and o_bin = sum of all 9 shadow bins.
  - This beat carries o_last; bin 8 no longer does.
  - Sum width is BIN_W+4 internally; the beat outputs the sum saturated to BIN_W.
- Undefined: exactly 9 beats, o_last on idx 8, and no sum logic is synthesised.

Test Plan:
- Histogram contents: 64 pixels, code=i%9, mag=1, o_ready=1 -> bins 8,7,7,7,7,7,7,7,7; o_last only on idx 8; o_err=0.
- Max magnitude: 64 pixels, code=4, mag=255 -> bin4=16320, all other bins 0, no wrap. With SUM_EN the 10th beat is 16320.
- Backpressure: o_ready=0 for 300 cycles while 128 pixels are offered -> i_ready drops at the 2nd cell's pix_cnt=63. Beats hold stable, no pixel is lost, and both cells drain correctly once o_ready=1.
- Invalid code: one pixel with code=12, mag=50 inside a cell -> o_err=1 and stays high. That cell's bin sums exclude the 50, and the cell still completes after 64 accepts.
- Reset mid-cell: reset after 30 pixels, then 64 pixels with code=0, mag=2 -> single cell with bin0=128, no stale beats, o_err=0.
- Random valid/ready toggling, 20 cells, compared against a reference model -> exact bin match; o_idx sequence is 0..8 per cell.
